// File: rtl/red_centroid_tracker.sv
// Red-pixel centroid tracker: classifies each active pixel, accumulates red-hit
// coordinates over a frame and divides the sums by the hit count at frame end.
module red_centroid_tracker #(
    parameter int unsigned H_RES     = 640,
    parameter int unsigned V_RES     = 480,
    parameter logic [7:0]  RED_MIN   = 8'd160,
    parameter logic [7:0]  GB_MAX    = 8'd80,
    parameter int unsigned MIN_COUNT = 16
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iDE,
    input  logic        iVS,
    input  logic [7:0]  iR,
    input  logic [7:0]  iG,
    input  logic [7:0]  iB,
    output logic [9:0]  oX,
    output logic [9:0]  oY,
    output logic [18:0] oCount,
    output logic        oFound,
    output logic        oValid,
    output logic        oBusy
);

    localparam int unsigned XW      = 10;
    localparam int unsigned YW      = 10;
    localparam int unsigned SW      = 28;
    localparam int unsigned CW      = 19;
    localparam int unsigned IW      = 5;
    localparam int unsigned DIV_CYC = 28;

    typedef enum logic [1:0] {ACCUM, LATCH, DIV, DONE} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            de_q, de_d;
    logic            vs_q, vs_d;
    logic            hit_q, hit_d;
    logic [XW-1:0]   hx_q, hx_d;
    logic [YW-1:0]   hy_q, hy_d;
    logic [SW-1:0]   sum_x_q, sum_x_d;
    logic [SW-1:0]   sum_y_q, sum_y_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   quo_x_q, quo_x_d;
    logic [SW-1:0]   quo_y_q, quo_y_d;
    logic [CW-1:0]   rem_x_q, rem_x_d;
    logic [CW-1:0]   rem_y_q, rem_y_d;
    logic [CW-1:0]   dvsr_q, dvsr_d;
    logic [IW-1:0]   dcnt_q, dcnt_d;
    logic [XW-1:0]   out_x_q, out_x_d;
    logic [YW-1:0]   out_y_q, out_y_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic            out_found_q, out_found_d;
    logic            out_valid_q, out_valid_d;
    logic            out_busy_q, out_busy_d;

    logic [SW-1:0]   sx_acc, sy_acc;
    logic [CW-1:0]   cnt_acc;
    logic [SW-1:0]   quo_x_nxt, quo_y_nxt;
    logic [CW-1:0]   rem_x_nxt, rem_y_nxt;
    logic            vs_rise, vs_fall, de_fall;

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    function automatic logic [SW+CW-1:0] div_step(input logic [SW-1:0] q,
                                                  input logic [CW-1:0] r,
                                                  input logic [CW-1:0] d);
        logic [CW:0]   sh;
        logic [SW-1:0] nq;
        sh = {r, q[SW-1]};
        nq = {q[SW-2:0], 1'b0};
        if (sh >= {1'b0, d}) begin
            sh    = sh - {1'b0, d};
            nq[0] = 1'b1;
        end
        return {nq, sh[CW-1:0]};
    endfunction

    assign {quo_x_nxt, rem_x_nxt} = div_step(quo_x_q, rem_x_q, dvsr_q);
    assign {quo_y_nxt, rem_y_nxt} = div_step(quo_y_q, rem_y_q, dvsr_q);

    assign vs_rise = iVS & ~vs_q;
    assign vs_fall = ~iVS & vs_q;
    assign de_fall = ~iDE & de_q;

    // Accumulator values including the hit still sitting in the pipeline register.
    assign sx_acc  = sum_x_q + (hit_q ? SW'(hx_q) : SW'(0));
    assign sy_acc  = sum_y_q + (hit_q ? SW'(hy_q) : SW'(0));
    assign cnt_acc = cnt_q + (hit_q ? CW'(1) : CW'(0));

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        de_d        = iDE;
        vs_d        = iVS;
        hit_d       = iDE && (iR >= RED_MIN) && (iG <= GB_MAX) && (iB <= GB_MAX);
        hx_d        = x_q;
        hy_d        = y_q;
        sum_x_d     = sx_acc;
        sum_y_d     = sy_acc;
        cnt_d       = cnt_acc;
        quo_x_d     = quo_x_q;
        quo_y_d     = quo_y_q;
        rem_x_d     = rem_x_q;
        rem_y_d     = rem_y_q;
        dvsr_d      = dvsr_q;
        dcnt_d      = dcnt_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_cnt_d   = out_cnt_q;
        out_found_d = out_found_q;
        out_valid_d = 1'b0;
        out_busy_d  = out_busy_q;

        // Raster coordinates, saturating at the last active pixel/line.
        if (vs_rise) begin
            x_d = '0;
            y_d = '0;
        end else if (de_fall) begin
            x_d = '0;
            if (y_q < YW'(V_RES - 1)) y_d = y_q + YW'(1);
        end else if (iDE && (x_q < XW'(H_RES - 1))) begin
            x_d = x_q + XW'(1);
        end

        case (state_q)
            ACCUM: begin
                if (vs_fall) state_d = LATCH;
            end
            LATCH: begin
                quo_x_d = sx_acc;
                quo_y_d = sy_acc;
                dvsr_d  = cnt_acc;
                rem_x_d = '0;
                rem_y_d = '0;
                dcnt_d  = '0;
                sum_x_d = '0;
                sum_y_d = '0;
                cnt_d   = '0;
                if (cnt_acc < CW'(MIN_COUNT)) begin
                    state_d     = DONE;
                    out_cnt_d   = cnt_acc;
                    out_found_d = 1'b0;
                    out_valid_d = 1'b1;
                end else begin
                    state_d    = DIV;
                    out_busy_d = 1'b1;
                end
            end
            DIV: begin
                quo_x_d = quo_x_nxt;
                quo_y_d = quo_y_nxt;
                rem_x_d = rem_x_nxt;
                rem_y_d = rem_y_nxt;
                dcnt_d  = dcnt_q + IW'(1);
                if (dcnt_q == IW'(DIV_CYC - 1)) begin
                    state_d     = DONE;
                    out_busy_d  = 1'b0;
                    out_x_d     = quo_x_nxt[XW-1:0];
                    out_y_d     = quo_y_nxt[YW-1:0];
                    out_cnt_d   = dvsr_q;
                    out_found_d = 1'b1;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= ACCUM;
            x_q         <= '0;
            y_q         <= '0;
            de_q        <= 1'b0;
            vs_q        <= 1'b0;
            hit_q       <= 1'b0;
            hx_q        <= '0;
            hy_q        <= '0;
            sum_x_q     <= '0;
            sum_y_q     <= '0;
            cnt_q       <= '0;
            quo_x_q     <= '0;
            quo_y_q     <= '0;
            rem_x_q     <= '0;
            rem_y_q     <= '0;
            dvsr_q      <= '0;
            dcnt_q      <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_cnt_q   <= '0;
            out_found_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            de_q        <= de_d;
            vs_q        <= vs_d;
            hit_q       <= hit_d;
            hx_q        <= hx_d;
            hy_q        <= hy_d;
            sum_x_q     <= sum_x_d;
            sum_y_q     <= sum_y_d;
            cnt_q       <= cnt_d;
            quo_x_q     <= quo_x_d;
            quo_y_q     <= quo_y_d;
            rem_x_q     <= rem_x_d;
            rem_y_q     <= rem_y_d;
            dvsr_q      <= dvsr_d;
            dcnt_q      <= dcnt_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_cnt_q   <= out_cnt_d;
            out_found_q <= out_found_d;
            out_valid_q <= out_valid_d;
            out_busy_q  <= out_busy_d;
        end
    end

    assign oX     = out_x_q;
    assign oY     = out_y_q;
    assign oCount = out_cnt_q;
    assign oFound = out_found_q;
    assign oValid = out_valid_q;
    assign oBusy  = out_busy_q;

endmodule

// File: doc/red_centroid_tracker.md
Name: red_centroid_tracker

Overview:
- Sits downstream of the RGB demosaic stage and beside the ball detector, in the VGA_CLK domain.
- Takes the 24-bit RGB pixel stream and classifies each active pixel as "red" or not.
- Accumulates the x/y coordinate sums and the hit count of red pixels over each frame.
- At frame end, divides the sums by the count to produce a per-frame centroid for the tracker and overlay logic.

Parameters:
- H_RES, 640, active pixels per line; x counter saturates at H_RES-1.
- V_RES, 480, active lines per frame; y counter saturates at V_RES-1.
- RED_MIN, 8'd160, minimum R for a red hit.
- GB_MAX, 8'd80, maximum G and maximum B for a red hit.
- MIN_COUNT, 16, minimum hits per frame for a valid detection.

Ports:
- iCLK, in, 1, pixel clock (VGA_CLK).
- iRST, in, 1, asynchronous active-high reset.
- iDE, in, 1, pixel valid (READ_Request); high for H_RES consecutive cycles per active line.
- iVS, in, 1, vertical active-area flag; high across all active lines of a frame.
- iR, in, 8, red component, valid when iDE=1.
- iG, in, 8, green component, valid when iDE=1.
- iB, in, 8, blue component, valid when iDE=1.
- oX, out, 10, centroid x of the last valid frame.
- oY, out, 10, centroid y of the last valid frame.
- oCount, out, 19, red-hit count of the last completed frame.
- oFound, out, 1, 1 if the last completed frame had count >= MIN_COUNT.
- oValid, out, 1, one-cycle pulse when oX/oY/oCount/oFound update.
- oBusy, out, 1, high while the divider runs.

Behaviour:
- Reset: all outputs 0; x=y=0; sums, count 0; state ACCUM.
- Coordinates:
  - x increments on each iDE=1 cycle.
  - On iDE falling edge: x clears to 0, y increments.
  - On iVS rising edge: x and y clear to 0.
  - Both saturate at H_RES-1 / V_RES-1; no wrap.
- Classification: hit = (iR >= RED_MIN) && (iG <= GB_MAX) && (iB <= GB_MAX) && iDE; registered with its x,y (1-cycle pipeline).
- Accumulation, per registered hit:
  - sum_x += x (28 bits)
  - sum_y += y (28 bits)
  - cnt += 1 (19 bits)
  - Widths cover a full 640x480 frame with no overflow.
- Frame end:
  - Triggered on the first cycle iVS is sampled low after being high.
  - FSM enters LATCH.
  - LATCH waits one cycle so the final pipelined hit is included, then copies sum_x/sum_y/cnt to divide registers and clears the accumulators.
- FSM states:
  - ACCUM: accumulates; on iVS falling edge -> LATCH.
  - LATCH: copy divide registers, clear accumulators; if cnt < MIN_COUNT -> DONE with oFound=0, else -> DIV.
  - DIV: two parallel restoring dividers (28-bit dividend, 19-bit divisor), one quotient bit per cycle, exactly 28 cycles; oBusy=1. Then -> DONE.
  - DONE: one cycle. Update oCount and oFound. If found, load oX/oY with the quotient low 10 bits (truncated, i.e. floor). Assert oValid. -> ACCUM.
- Latency:
  - oValid is 30 cycles after the iVS falling-edge detect cycle (found case).
  - oValid is 2 cycles after it for a not-found frame.
- Not-found frame: oX/oY hold previous values; oCount still updates; oFound=0.
- iVS rises during DIV: the new frame accumulates normally; the divide operates only on latched copies; no interference.
- iVS falls while not in ACCUM: cannot occur at legal timing; ignored. The edge is dropped and the frame's sums stay in the accumulators.
- Outputs hold between oValid pulses.
- iRST asserted mid-DIV: immediate return to reset values; no oValid for the aborted frame.

Test Plan:
- Reset -> all outputs 0, oBusy 0; first partial frame after reset is accumulated normally.
- MIN_COUNT=1; a single red pixel (R=255, G=B=0) at x=100, y=50 in a 640x480 frame -> oValid 30 cycles after the iVS fall; oX=100, oY=50, oCount=1, oFound=1.
- 10x10 red block at x 200..209, y 300..309 -> oCount=100, oX=204 (floor 204.5), oY=304.
- Frame with no red, after a valid frame -> oValid at +2 cycles; oFound=0, oCount=0; oX/oY unchanged.
- Full-frame red -> oCount=307200, oX=319, oY=239, no overflow.
- Pixel with R=160, G=80, B=81 -> no hit; R=159, G=0, B=0 -> no hit.
- iRST pulsed at cycle 10 of DIV -> outputs 0, no oValid; the next frame computes correctly.
